// File: rtl/axis_pattern_source_if.sv
// AXI4-Stream bundle between the pattern source and its sink.
//   tdata  : stream data word
//   tvalid : master has a beat available
//   tready : sink can accept a beat
//   tlast  : final beat of a burst
// Modports: master (drives tdata/tvalid/tlast), slave (drives tready).
interface axis_pattern_source_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_pattern_source.sv
// AXI4-Stream burst generator. It emits `length` incrementing words starting
// at `seed`, with `gap` idle cycles after each accepted beat and TLAST on
// the final beat.
//   clock      : rising-edge clock
//   reset      : asynchronous active-low reset
//   start      : one-cycle burst request, honoured only when idle
//   seed       : first data word of the burst
//   length     : number of beats; 0 gives an immediate done pulse
//   gap        : idle cycles inserted after each accepted beat
//   m_axis     : stream master (tdata/tvalid/tlast out, tready in)
//   busy       : burst in progress
//   done       : one-cycle pulse when a burst completes
//   beat_count : beats accepted in the current or most recent burst
// Every output comes directly from a flop, so tready has no combinational
// path to any output.
module axis_pattern_source #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned GAP_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic [GAP_WIDTH-1:0]  gap,
    axis_pattern_source_if.master m_axis,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  beat_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [GAP_WIDTH-1:0]  gap_q, gap_d;
    logic [GAP_WIDTH-1:0]  gcnt_q, gcnt_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        len_d    = len_q;
        beat_d   = beat_q;
        gap_d    = gap_q;
        gcnt_d   = gcnt_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    data_d = seed;
                    len_d  = length;
                    gap_d  = gap;
                    beat_d = '0;
                    if (length != '0) begin
                        state_d  = SEND;
                        tvalid_d = 1'b1;
                        busy_d   = 1'b1;
                        tlast_d  = (length == LEN_WIDTH'(1));
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (tvalid_q && m_axis.tready) begin
                    beat_d = beat_q + LEN_WIDTH'(1);
                    data_d = data_q + DATA_WIDTH'(1);
                    if (tlast_q) begin
                        state_d  = IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else if (gap_q == '0) begin
                        tlast_d = (beat_d == len_q - LEN_WIDTH'(1));
                    end else begin
                        state_d  = GAP;
                        gcnt_d   = gap_q;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end
                end
            end
            GAP: begin
                gcnt_d = gcnt_q - GAP_WIDTH'(1);
                // Leaving on the count of 1 yields exactly `gap` idle cycles.
                if (gcnt_q == GAP_WIDTH'(1)) begin
                    state_d  = SEND;
                    tvalid_d = 1'b1;
                    tlast_d  = (beat_q == len_q - LEN_WIDTH'(1));
                end
            end
            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            gap_q    <= '0;
            gcnt_q   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            gcnt_q   <= gcnt_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign m_axis.tdata  = data_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign beat_count    = beat_q;

endmodule

// File: tb/tb_axis_pattern_source.sv
module tb_axis_pattern_source;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] seed = '0;
    logic [15:0] length = '0;
    logic [7:0]  gap = '0;
    logic        busy;
    logic        done;
    logic [15:0] beat_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    axis_pattern_source_if #(.DATA_WIDTH(32)) axis ();

    axis_pattern_source #(
        .DATA_WIDTH(32),
        .LEN_WIDTH (16),
        .GAP_WIDTH (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .seed      (seed),
        .length    (length),
        .gap       (gap),
        .m_axis    (axis.master),
        .busy      (busy),
        .done      (done),
        .beat_count(beat_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tvalid"}, 32'(axis.tvalid), 32'd0);
        chk({tag, "_tlast"},  32'(axis.tlast),  32'd0);
        chk({tag, "_tdata"},  axis.tdata,       32'd0);
        chk({tag, "_busy"},   32'(busy),        32'd0);
        chk({tag, "_done"},   32'(done),        32'd0);
        chk({tag, "_beats"},  32'(beat_count),  32'd0);
    endtask

    // Reference: beat i carries seed+i (mod 2^32), tlast only on beat len-1,
    // exactly g tvalid-low cycles between an accepted beat and the next one,
    // done one cycle after the last acceptance.
    // mode: 0 tready always high, 1 random, 2 pattern 1,0,0,1,0,1 repeating.
    task automatic run_burst(input logic [31:0] s, input int unsigned len,
                             input int unsigned g, input int unsigned mode,
                             input bit mid, input bit chain);
        int unsigned idx = 0;
        int unsigned low = 0;
        int unsigned pos = 0;
        bit          after_hs = 1'b0;
        bit          fin = 1'b0;
        bit          hs;
        logic [5:0]  pat = 6'b101001;
        logic [31:0] exp_data;

        start  = 1'b1;
        seed   = s;
        length = 16'(len);
        gap    = 8'(g);
        tick();
        start = 1'b0;

        if (len == 0) begin
            chk("zl_done",   32'(done),         32'd1);
            chk("zl_tvalid", 32'(axis.tvalid),  32'd0);
            chk("zl_busy",   32'(busy),         32'd0);
            chk("zl_beats",  32'(beat_count),   32'd0);
            if (!chain) begin
                tick();
                chk("zl_done_clr", 32'(done),        32'd0);
                chk("zl_tvalid2",  32'(axis.tvalid), 32'd0);
            end
            return;
        end

        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            chk("busy",       32'(busy),       32'd1);
            chk("done_low",   32'(done),       32'd0);
            chk("beat_count", 32'(beat_count), idx);
            if (axis.tvalid) begin
                if (after_hs) chk("gap_len", low, g);
                after_hs = 1'b0;
                exp_data = s + idx;
                chk("tdata", axis.tdata, exp_data);
                chk("tlast", 32'(axis.tlast), 32'(idx == len - 1));
            end else begin
                low++;
                if (low > g) chk("gap_overrun", low, g);
            end

            case (mode)
                0:       axis.tready = 1'b1;
                1:       axis.tready = 1'($urandom_range(0, 1));
                default: axis.tready = pat[pos % 6];
            endcase
            pos++;

            if (mid && cyc == 3) begin
                start  = 1'b1;
                seed   = ~s;
                length = 16'd5;
            end

            hs = axis.tvalid && axis.tready;
            tick();
            start = 1'b0;

            if (hs) begin
                idx++;
                low = 0;
                after_hs = 1'b1;
                if (idx == len) begin
                    fin = 1'b1;
                    chk("end_tvalid", 32'(axis.tvalid), 32'd0);
                    chk("end_tlast",  32'(axis.tlast),  32'd0);
                    chk("end_busy",   32'(busy),        32'd0);
                    chk("end_done",   32'(done),        32'd1);
                    chk("end_beats",  32'(beat_count),  len);
                    if (!chain) begin
                        tick();
                        chk("done_clr",   32'(done),        32'd0);
                        chk("hold_beats", 32'(beat_count),  len);
                        chk("idle_valid", 32'(axis.tvalid), 32'd0);
                    end
                end
            end
        end
        if (!fin) chk("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        axis.tready = 1'b0;
        #12;
        chk_all_zero("rst");
        reset = 1'b1;
        tick();
        chk_all_zero("post_rst");

        // back-to-back
        run_burst(32'h0000_0010, 4, 0, 0, 1'b0, 1'b0);
        // backpressure pattern
        run_burst(32'hA000_0000, 3, 0, 2, 1'b0, 1'b0);
        // gap with wrap-around
        run_burst(32'hFFFF_FFFE, 3, 2, 0, 1'b0, 1'b0);
        // zero length
        run_burst(32'h1234_5678, 0, 0, 0, 1'b0, 1'b0);
        // start while busy is ignored
        run_burst(32'h0000_0100, 5, 0, 0, 1'b1, 1'b0);

        // reset mid-burst after two beats accepted
        axis.tready = 1'b1;
        start  = 1'b1;
        seed   = 32'h5555_0000;
        length = 16'd6;
        gap    = 8'd0;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_beats", 32'(beat_count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        chk("rst_no_done", 32'(done), 32'd0);
        #2;
        reset = 1'b1;
        tick();
        chk_all_zero("rst_release");
        run_burst(32'h7777_0000, 2, 0, 0, 1'b0, 1'b0);

        // restart in the done cycle
        run_burst(32'h0000_0200, 3, 1, 0, 1'b0, 1'b1);
        run_burst(32'h0000_0300, 2, 0, 0, 1'b0, 1'b0);
        run_burst(32'h0000_0400, 0, 0, 0, 1'b0, 1'b1);
        run_burst(32'h0000_0500, 2, 0, 1, 1'b0, 1'b0);

        // randomized bursts
        for (int n = 0; n < 25; n++) begin
            run_burst($urandom, $urandom_range(0, 8), $urandom_range(0, 3),
                      $urandom_range(0, 2), 1'b0, 1'($urandom_range(0, 1)));
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_pattern_source.md
# axis_pattern_source

Synchronous AXI4-Stream master that generates bursts of incrementing 32-bit test words with TLAST on the final beat. It drives the S_AXIS side of the stream FIFO, acting as the transmitter for that sink, in loopback and throughput benches and in on-chip self-test. Software or a bench starts a burst with a seed, length and inter-beat gap. The block honours TREADY backpressure and reports completion.

## Interface
- DATA_WIDTH, 32: width of m_axis_tdata and seed.
- LEN_WIDTH, 16: width of length and beat_count.
- GAP_WIDTH, 8: width of gap.

- clock  in  1  sole clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- seed  in  DATA_WIDTH  first data word of the burst.
- length  in  LEN_WIDTH  number of beats in the burst; 0 is legal.
- gap  in  GAP_WIDTH  idle cycles inserted after each accepted beat.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready from the downstream sink.
- m_axis_tlast  out  1  high on the final beat of the burst.
- busy  out  1  high while a burst is in progress (SEND or GAP).
- done  out  1  one-cycle pulse after the final beat is accepted, or after a zero-length start.
- beat_count  out  LEN_WIDTH  beats accepted in the current or most recent burst.

## Operation
- States: IDLE, SEND, GAP. All outputs are registered.
- IDLE:
  - If start=1, latch seed, length and gap, clear beat_count, and load the data register with seed.
  - If length != 0, go to SEND. If length = 0, stay in IDLE and pulse done on the next cycle.
  - start while busy=1 is ignored.
- SEND:
  - tvalid=1 and tdata=data register. tlast=1 exactly when beat_count = length-1.
  - Handshake is tvalid & tready at a rising edge. Without a handshake, tdata and tlast hold stable and tvalid stays high.
  - On a handshake:
    - beat_count increments and data increments by 1, wrapping modulo 2^DATA_WIDTH.
    - If the beat was the last: go to IDLE, with done=1 for one cycle.
    - Otherwise, if gap = 0, stay in SEND and present the next beat on the next cycle.
    - Otherwise, go to GAP with gap counter = gap.
- GAP: tvalid=0. The counter decrements each cycle, and the state returns to SEND on the cycle after the counter reaches 1. This gives exactly `gap` cycles with tvalid low.
- A start that arrives in the same cycle that done is high is accepted, because the state is already IDLE.
- beat_count holds its final value in IDLE until the next start.
- Reset asserted mid-burst: all state clears immediately and the burst is abandoned with no done pulse.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0, beat_count=0, state IDLE.
- start at edge N: tvalid=1 with tdata=seed visible after edge N. busy rises together with tvalid.
- Throughput:
  - gap=0 with tready held high: one beat per clock.
  - Otherwise: one beat per (1+gap) clocks when tready is high on arrival.
- Last handshake at edge M: after edge M, tvalid=0, tlast=0, busy=0, done=1. done clears after edge M+1.
- Zero-length start at edge N: done=1 after edge N, busy never rises, and no beat is sent.
- tready has no combinational path to any output.
- tready high while tvalid=0 has no effect.

## Test plan
- Back-to-back: seed=0x0000_0010, length=4, gap=0, tready=1. Required: 4 consecutive beats 0x10, 0x11, 0x12, 0x13; tlast only on 0x13; done one cycle later; beat_count=4.
- Backpressure: seed=0xA000_0000, length=3, gap=0, tready toggles 1,0,0,1,0,1. Required: data and tlast stable while stalled; exactly 3 beats accepted, in order, with no duplicates or losses.
- Gap and wrap: seed=0xFFFF_FFFE, length=3, gap=2, tready=1. Required: beats 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000, separated by exactly 2 tvalid-low cycles each.
- Zero length and start-while-busy:
  - length=0: done pulses after one cycle, tvalid never rises.
  - A second start during a length=5 burst is ignored; only 5 beats are sent.
- Reset mid-burst: assert reset low asynchronously after beat 2 of 6. Required: all outputs go to 0 immediately and no done pulse occurs. After release, a new start with length=2 sends 2 beats starting at the new seed.
- Restart on done: assert start in the done cycle. Required: the new burst begins on the next cycle with the new seed, and beat_count is cleared.
